servo_slew_limiter: RTL
=======================

Name: servo_slew_limiter

Overview:
Sits between the joystick-to-pulse-width mapping and each servo PWM generator. It takes a raw, possibly out-of-range pulse-width target in microseconds and produces the servo command. The command is clamped to the safe range and moves toward the target by at most STEP_US per update tick, which removes jerks when the joystick moves quickly or the selected servo changes. One instance per servo.

Parameters:
UPDATE_DIV, 240000, CLK cycles per update tick (12 MHz / 50 Hz servo frame); minimum 2.
MIN_US, 650, lower clamp for the command (us).
MAX_US, 2600, upper clamp for the command (us).
CENTER_US, 1500, reset value of the command and the target.
STEP_US, 20, maximum change of the command per tick (us); must be at least 1.
DEADBAND_US, 8, target-change threshold; used only when SERVO_SLEW_DEADBAND_EN is defined.

Ports:
CLK  input  1  system clock
RST_N  input  1  reset, synchronous, active-low
target_valid  input  1  capture target this cycle
target  input  32  signed requested pulse width (us); may be negative or above range
hold  input  1  freeze the command while high
cmd_out  output  32  unsigned pulse width to the servo PWM (us)
moving  output  1  high in RAMP_UP or RAMP_DOWN
at_target  output  1  high in IDLE
clamped  output  1  last captured target was out of range
tick  output  1  one-cycle update strobe (debug)

Behaviour:
- Reset, applied when RST_N is low at a CLK edge:
  - cmd_out = CENTER_US; tgt_q = CENTER_US; prescaler = 0; state = IDLE.
  - moving = 0, at_target = 1, clamped = 0, tick = 0.
  - Reset mid-ramp behaves the same: cmd_out returns to CENTER_US at that edge.
- Target capture:
  - When target_valid = 1, tgt_q is loaded at the next edge with target clamped to [MIN_US, MAX_US]. The comparison is signed 32-bit.
  - clamped is loaded with 1 if clamping occurred, otherwise 0. It is updated only on capture.
  - Targets are captured in every state, including HOLD.
- Prescaler:
  - Counts 0 to UPDATE_DIV-1 and wraps to 0. It runs freely, including during hold.
  - tick is a registered output, high for the one cycle after the counter reaches UPDATE_DIV-1.
  - A step is applied on the edge where tick = 1.
- State machine (IDLE, RAMP_UP, RAMP_DOWN, HOLD), registered:
  - The next state is evaluated every cycle from tgt_q and cmd_out after that cycle's step.
  - If hold = 1, go to HOLD.
  - Otherwise: tgt_q == cmd_out goes to IDLE; tgt_q > cmd_out goes to RAMP_UP; tgt_q < cmd_out goes to RAMP_DOWN.
  - On release of hold, leave HOLD for the state given by the comparison one edge later.
- Step, applied only on a tick edge and only in a RAMP state:
  - RAMP_UP: cmd_out += min(STEP_US, tgt_q - cmd_out).
  - RAMP_DOWN: cmd_out -= min(STEP_US, cmd_out - tgt_q).
  - The command never overshoots, and it always stays within [MIN_US, MAX_US].
- Latency:
  - target_valid in cycle N gives tgt_q in N+1 and state in N+2.
  - A tick arriving in N+1 is ignored because the state is still IDLE; the first step happens on the first tick at or after N+2.
- Simultaneous target_valid and tick: the step uses the old tgt_q, and the new target applies from the next tick.
- Direction reversal mid-ramp: the state switches at the next comparison with no extra step in the old direction.
- In HOLD and IDLE, cmd_out is unchanged.
- moving and at_target decode the registered state, so both are 0 in HOLD.

Optional Feature:
SERVO_SLEW_DEADBAND_EN
- Defined: a valid target is captured only if |clamp(target) - tgt_q| > DEADBAND_US. Otherwise tgt_q and clamped are unchanged. This suppresses joystick ADC jitter.
- Undefined: every valid target is captured, and DEADBAND_US is unused.

Test Plan (UPDATE_DIV=4, STEP_US=20 unless noted):
1. Hold RST_N low for 2 cycles -> cmd_out=1500, at_target=1, moving=0, clamped=0, tick pulses every 4 cycles after release.
2. target=1600 pulsed for 1 cycle -> cmd_out steps 1520, 1540, 1560, 1580, 1600 on successive ticks, never exceeds 1600, then at_target=1.
3. target=1510 -> one partial step to 1510; target=-200 -> tgt 650, clamped=1, cmd_out ramps down to 650; target=3000 -> tgt 2600, clamped=1; target=2000 -> clamped=0.
4. Ramp toward 1600, raise hold at cmd_out=1540 for 10 ticks -> cmd_out stays 1540, state HOLD, moving=0; release -> resumes 1560.
5. Target 1600; after reaching 1540 send target 1450 -> next steps 1520, 1500, 1480, 1460, 1450 (no 1560); RST_N low mid-ramp -> cmd_out=1500 at that edge.
6. Macro defined, DEADBAND_US=8: from 1500, target 1505 -> ignored, at_target stays 1; target 1510 -> ramps to 1510. Macro undefined: 1505 is captured and reached.

Source files
------------

// File: rtl/servo_slew_limiter.sv
`default_nettype none
// ============================================================================
// Module   : servo_slew_limiter
// Purpose  : Clamps a raw pulse-width target and slews the servo command
//            toward it by at most STEP_US per update tick.
// Option   : SERVO_SLEW_DEADBAND_EN - ignore target changes within DEADBAND_US
// Revision : 1.0 - initial release
// ============================================================================
module servo_slew_limiter #(
   parameter int UPDATE_DIV  = 240000,
   parameter int MIN_US      = 650,
   parameter int MAX_US      = 2600,
   parameter int CENTER_US   = 1500,
   parameter int STEP_US     = 20,
   parameter int DEADBAND_US = 8
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        target_valid,
   input  logic [31:0] target,
   input  logic        hold,
   output logic [31:0] cmd_out,
   output logic        moving,
   output logic        at_target,
   output logic        clamped,
   output logic        tick
);

   localparam int          c_presc_w = $clog2(UPDATE_DIV);
   localparam logic [31:0] c_min     = 32'(MIN_US);
   localparam logic [31:0] c_max     = 32'(MAX_US);
   localparam logic [31:0] c_center  = 32'(CENTER_US);
   localparam logic [31:0] c_step    = 32'(STEP_US);
   localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(UPDATE_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_RAMP_UP   = 2'd1,
      S_RAMP_DOWN = 2'd2,
      S_HOLD      = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic [c_presc_w-1:0]  r_presc;
   logic                  r_tick;
   logic [31:0]           r_cmd;
   logic [31:0]           r_tgt;
   logic                  r_clamped;

   logic [31:0]           w_clamp_tgt;
   logic                  w_clip;
   logic                  w_accept;
   logic [31:0]           w_up_gap;
   logic [31:0]           w_dn_gap;
   logic [31:0]           w_cmd_next;

   // Signed compare so negative requests clamp to the low end.
   always_comb begin
      w_clamp_tgt = target;
      w_clip      = 1'b0;
      if ($signed(target) < $signed(c_min)) begin
         w_clamp_tgt = c_min;
         w_clip      = 1'b1;
      end else if ($signed(target) > $signed(c_max)) begin
         w_clamp_tgt = c_max;
         w_clip      = 1'b1;
      end
   end

`ifdef SERVO_SLEW_DEADBAND_EN
   logic signed [32:0] w_db_diff;
   logic signed [32:0] w_db_mag;
   assign w_db_diff = $signed({1'b0, w_clamp_tgt}) - $signed({1'b0, r_tgt});
   assign w_db_mag  = (w_db_diff < 0) ? -w_db_diff : w_db_diff;
   assign w_accept  = target_valid && (w_db_mag > 33'(DEADBAND_US));
`else
   assign w_accept  = target_valid;
`endif

   assign w_up_gap = r_tgt - r_cmd;
   assign w_dn_gap = r_cmd - r_tgt;

   // Gap guards stop a stale ramp direction from stepping after a reversal.
   always_comb begin
      w_cmd_next = r_cmd;
      if (r_tick) begin
         if (r_state == S_RAMP_UP && r_tgt > r_cmd)
            w_cmd_next = r_cmd + ((w_up_gap > c_step) ? c_step : w_up_gap);
         else if (r_state == S_RAMP_DOWN && r_tgt < r_cmd)
            w_cmd_next = r_cmd - ((w_dn_gap > c_step) ? c_step : w_dn_gap);
      end
   end

   always_comb begin
      w_state_next = S_IDLE;
      if (hold)
         w_state_next = S_HOLD;
      else if (r_tgt > w_cmd_next)
         w_state_next = S_RAMP_UP;
      else if (r_tgt < w_cmd_next)
         w_state_next = S_RAMP_DOWN;
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_presc   <= '0;
         r_tick    <= 1'b0;
         r_cmd     <= c_center;
         r_tgt     <= c_center;
         r_clamped <= 1'b0;
         r_state   <= S_IDLE;
      end else begin
         r_presc <= (r_presc == c_presc_last) ? '0 : r_presc + 1'b1;
         r_tick  <= (r_presc == c_presc_last);
         r_cmd   <= w_cmd_next;
         r_state <= w_state_next;
         if (w_accept) begin
            r_tgt     <= w_clamp_tgt;
            r_clamped <= w_clip;
         end
      end
   end

   assign cmd_out   = r_cmd;
   assign tick      = r_tick;
   assign clamped   = r_clamped;
   assign moving    = (r_state == S_RAMP_UP) || (r_state == S_RAMP_DOWN);
   assign at_target = (r_state == S_IDLE);

endmodule
`default_nettype wire
